// File: rtl/pg_serial_carry_resolver_if.sv
// pg_serial_carry_resolver_if: p/g chunk input stream and sum chunk output stream (out_ovf only under PG_OVF_EN)
interface pg_serial_carry_resolver_if #(
  parameter int CHUNK  = 2,
  parameter int BEAT_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [CHUNK-1:0]  in_p;
  logic [CHUNK-1:0]  in_g;
  logic              in_first;
  logic              in_last;
  logic              cin;
  logic              out_valid;
  logic              out_ready;
  logic [CHUNK-1:0]  out_sum;
  logic [BEAT_W-1:0] out_beat;
  logic              out_last;
  logic              out_cout;
  logic              err;
`ifdef PG_OVF_EN
  logic              out_ovf;
  modport master (
    output in_valid, in_p, in_g, in_first, in_last, cin, out_ready,
    input  in_ready, out_valid, out_sum, out_beat, out_last, out_cout, err, out_ovf
  );
  modport slave (
    input  in_valid, in_p, in_g, in_first, in_last, cin, out_ready,
    output in_ready, out_valid, out_sum, out_beat, out_last, out_cout, err, out_ovf
  );
`else
  modport master (
    output in_valid, in_p, in_g, in_first, in_last, cin, out_ready,
    input  in_ready, out_valid, out_sum, out_beat, out_last, out_cout, err
  );
  modport slave (
    input  in_valid, in_p, in_g, in_first, in_last, cin, out_ready,
    output in_ready, out_valid, out_sum, out_beat, out_last, out_cout, err
  );
`endif
endinterface

// File: rtl/pg_serial_carry_resolver.sv
// pg_serial_carry_resolver: digit-serial carry resolution of p/g chunks into registered sum chunks; PG_OVF_EN adds out_ovf
module pg_serial_carry_resolver #(
  parameter int CHUNK     = 2,
  parameter int MAX_BEATS = 16,
  parameter int BEAT_W    = 4
) (
  input logic clk,
  input logic rst,
  pg_serial_carry_resolver_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t            state;
  state_t            state_n;
  logic              carry_q;
  logic [BEAT_W-1:0] beat_q;
  logic              accept;
  logic              drop;
  logic              load;
  logic              restart;
  logic              overrun;
  logic              eff_last;
  logic              err_n;
  logic [BEAT_W-1:0] idx;
  logic [CHUNK:0]    c;
  logic [CHUNK-1:0]  sum;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;

  // ripple the carry through the chunk, seeded from cin on a first beat
  always_comb begin
    c = '0;
    sum = '0;
    c[0] = bus.in_first ? bus.cin : carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      c[i+1] = bus.in_g[i] | (bus.in_p[i] & c[i]);
      sum[i] = bus.in_p[i] ^ c[i];
    end
  end

  // classify the accepted beat and pick the next FSM state
  always_comb begin
    idx = bus.in_first ? '0 : beat_q;
    drop = accept && state == IDLE && !bus.in_first;
    load = accept && !drop;
    restart = load && state == RUN && bus.in_first;
    eff_last = bus.in_last || idx == BEAT_W'(MAX_BEATS - 1);
    overrun = load && idx == BEAT_W'(MAX_BEATS - 1) && !bus.in_last;
    err_n = drop || restart || overrun;
    state_n = load ? (eff_last ? IDLE : RUN) : state;
  end

  // FSM state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;

  // carry/beat tracking and the output register, which holds while stalled
  always_ff @(posedge clk)
    if (rst) begin
      carry_q <= 1'b0;
      beat_q <= '0;
      bus.err <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sum <= '0;
      bus.out_beat <= '0;
      bus.out_last <= 1'b0;
      bus.out_cout <= 1'b0;
`ifdef PG_OVF_EN
      bus.out_ovf <= 1'b0;
`endif
    end else begin
      bus.err <= err_n;
      if (load) begin
        carry_q <= c[CHUNK];
        beat_q <= idx + 1'b1;
        bus.out_valid <= 1'b1;
        bus.out_sum <= sum;
        bus.out_beat <= idx;
        bus.out_last <= eff_last;
        bus.out_cout <= eff_last & c[CHUNK];
`ifdef PG_OVF_EN
        bus.out_ovf <= eff_last & (c[CHUNK] ^ c[CHUNK-1]);
`endif
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
endmodule
